// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running VGA raster timing generator.
//
// Produces the beam position, sync pulses, display-area and line/frame strobes, and a
// look-ahead fetch position LOOKAHEAD pixels ahead in raster order. Pixel sources with an
// L = LOOKAHEAD cycle pipeline sample fetch_x/fetch_y so that their output lines up with
// counter_x/counter_y.
//
// Ports:
//   clk              pixel clock
//   rst              synchronous, active-high reset
//   hsync_out        horizontal sync, active at HSYNC_POL
//   vsync_out        vertical sync, active at VSYNC_POL (line based)
//   counter_x/y      current beam column / line
//   in_display_area  beam inside the visible area
//   line_start       high when counter_x == 0
//   frame_start      high when counter_x == 0 and counter_y == 0
//   fetch_x/y        look-ahead position
//   fetch_valid      look-ahead position inside the visible area
//
// All outputs are registered; flags are derived from the next-state counters so they
// always describe the position shown on the same cycle.

module vga_timing_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0,
  parameter int unsigned LOOKAHEAD = 2,
  parameter int unsigned CW        = 10
) (
  input  logic          clk,
  input  logic          rst,
  output logic          hsync_out,
  output logic          vsync_out,
  output logic [CW-1:0] counter_x,
  output logic [CW-1:0] counter_y,
  output logic          in_display_area,
  output logic          line_start,
  output logic          frame_start,
  output logic [CW-1:0] fetch_x,
  output logic [CW-1:0] fetch_y,
  output logic          fetch_valid
);

  localparam int unsigned H_TOTAL    = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL    = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned H_SYNC_BEG = H_VISIBLE + H_FRONT;
  localparam int unsigned H_SYNC_END = H_SYNC_BEG + H_SYNC;
  localparam int unsigned V_SYNC_BEG = V_VISIBLE + V_FRONT;
  localparam int unsigned V_SYNC_END = V_SYNC_BEG + V_SYNC;

  localparam logic [CW-1:0] H_LAST      = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST      = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] FETCH_START = CW'(LOOKAHEAD);
  localparam logic [CW-1:0] ONE         = CW'(1);

  // Low while in reset; the first cycle it is low is the START cycle.
  logic running_q;

  logic [CW-1:0] cx_d, cy_d, fx_d, fy_d;
  logic [31:0]   cx_w, cy_w, fx_w, fy_w;
  logic          hs_act, vs_act, de_d, fv_d;

  // Next-state positions. Out of reset (START) the beam restarts at (0,0) and the fetch
  // position at (LOOKAHEAD,0); LOOKAHEAD < H_TOTAL so the fetch start stays on line 0.
  always_comb begin
    cx_d = '0;
    cy_d = '0;
    fx_d = FETCH_START;
    fy_d = '0;
    if (running_q) begin
      if (counter_x == H_LAST) begin
        cx_d = '0;
        cy_d = (counter_y == V_LAST) ? '0 : counter_y + ONE;
      end else begin
        cx_d = counter_x + ONE;
        cy_d = counter_y;
      end
      if (fetch_x == H_LAST) begin
        fx_d = '0;
        fy_d = (fetch_y == V_LAST) ? '0 : fetch_y + ONE;
      end else begin
        fx_d = fetch_x + ONE;
        fy_d = fetch_y;
      end
    end
  end

  // Compare in 32 bits so sync end points equal to the total still fit.
  always_comb begin
    cx_w   = 32'(cx_d);
    cy_w   = 32'(cy_d);
    fx_w   = 32'(fx_d);
    fy_w   = 32'(fy_d);
    hs_act = (cx_w >= H_SYNC_BEG) && (cx_w < H_SYNC_END);
    vs_act = (cy_w >= V_SYNC_BEG) && (cy_w < V_SYNC_END);
    de_d   = (cx_w < H_VISIBLE) && (cy_w < V_VISIBLE);
    fv_d   = (fx_w < H_VISIBLE) && (fy_w < V_VISIBLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      running_q       <= 1'b0;
      counter_x       <= '0;
      counter_y       <= '0;
      fetch_x         <= '0;
      fetch_y         <= '0;
      hsync_out       <= ~HSYNC_POL;
      vsync_out       <= ~VSYNC_POL;
      in_display_area <= 1'b0;
      line_start      <= 1'b0;
      frame_start     <= 1'b0;
      fetch_valid     <= 1'b0;
    end else begin
      running_q       <= 1'b1;
      counter_x       <= cx_d;
      counter_y       <= cy_d;
      fetch_x         <= fx_d;
      fetch_y         <= fy_d;
      hsync_out       <= hs_act ? HSYNC_POL : ~HSYNC_POL;
      vsync_out       <= vs_act ? VSYNC_POL : ~VSYNC_POL;
      in_display_area <= de_d;
      line_start      <= (cx_d == '0);
      frame_start     <= (cx_d == '0) && (cy_d == '0);
      fetch_valid     <= fv_d;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, rst2;
  logic       hs, vs, de, ls, fs, fv;
  logic [9:0] cx, cy, fx, fy;
  logic       s_hs, s_vs, s_de, s_ls, s_fs, s_fv;
  logic [3:0] s_cx, s_cy, s_fx, s_fy;

  vga_timing_gen dut (
    .clk(clk), .rst(rst), .hsync_out(hs), .vsync_out(vs),
    .counter_x(cx), .counter_y(cy), .in_display_area(de),
    .line_start(ls), .frame_start(fs), .fetch_x(fx), .fetch_y(fy), .fetch_valid(fv)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .LOOKAHEAD(0), .CW(4)
  ) dut_small (
    .clk(clk), .rst(rst2), .hsync_out(s_hs), .vsync_out(s_vs),
    .counter_x(s_cx), .counter_y(s_cy), .in_display_area(s_de),
    .line_start(s_ls), .frame_start(s_fs), .fetch_x(s_fx), .fetch_y(s_fy),
    .fetch_valid(s_fv)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".cx"}, int'(cx), 0);
    chk({tag, ".cy"}, int'(cy), 0);
    chk({tag, ".fx"}, int'(fx), 0);
    chk({tag, ".fy"}, int'(fy), 0);
    chk({tag, ".hsync"}, int'(hs), 1);
    chk({tag, ".vsync"}, int'(vs), 1);
    chk({tag, ".de"}, int'(de), 0);
    chk({tag, ".line_start"}, int'(ls), 0);
    chk({tag, ".frame_start"}, int'(fs), 0);
    chk({tag, ".fetch_valid"}, int'(fv), 0);
  endtask

  typedef struct {
    int k;
    int cx, cy, fx, fy;
    int hs, vs, de, ls, fs, fv;
  } vec_t;

  localparam int NVEC = 18;
  localparam int MIDK = 420000 + 200 * 800 + 300;

  initial begin
    vec_t tbl [NVEC];
    int   ti, mx, my, fk, mfx, mfy;
    int   e_pos, e_fetch, e_hs, e_vs, e_de, e_strb, e_fv, e_hold;
    int   hs_low0, de_cnt0, vs_low, de_bad, last_fs, fs_gap, s_fs_cnt;
    bit   xhs, xvs, xde, xls, xfs, xfv;

    //         k       cx   cy   fx   fy   hs vs de ls fs fv
    tbl[0]  = '{0,      0,   0,   2,   0,   1, 1, 1, 1, 1, 1};
    tbl[1]  = '{639,    639, 0,   641, 0,   1, 1, 1, 0, 0, 0};
    tbl[2]  = '{640,    640, 0,   642, 0,   1, 1, 0, 0, 0, 0};
    tbl[3]  = '{655,    655, 0,   657, 0,   1, 1, 0, 0, 0, 0};
    tbl[4]  = '{656,    656, 0,   658, 0,   0, 1, 0, 0, 0, 0};
    tbl[5]  = '{751,    751, 0,   753, 0,   0, 1, 0, 0, 0, 0};
    tbl[6]  = '{752,    752, 0,   754, 0,   1, 1, 0, 0, 0, 0};
    tbl[7]  = '{799,    799, 0,   1,   1,   1, 1, 0, 0, 0, 1};
    tbl[8]  = '{800,    0,   1,   2,   1,   1, 1, 1, 1, 0, 1};
    tbl[9]  = '{8798,   798, 10,  0,   11,  1, 1, 0, 0, 0, 1};
    tbl[10] = '{80637,  637, 100, 639, 100, 1, 1, 1, 0, 0, 1};
    tbl[11] = '{80638,  638, 100, 640, 100, 1, 1, 1, 0, 0, 0};
    tbl[12] = '{384000, 0,   480, 2,   480, 1, 1, 0, 1, 0, 0};
    tbl[13] = '{392000, 0,   490, 2,   490, 1, 0, 0, 1, 0, 0};
    tbl[14] = '{393599, 799, 491, 1,   492, 1, 0, 0, 0, 0, 0};
    tbl[15] = '{393600, 0,   492, 2,   492, 1, 1, 0, 1, 0, 0};
    tbl[16] = '{419999, 799, 524, 1,   0,   1, 1, 0, 0, 0, 1};
    tbl[17] = '{420000, 0,   0,   2,   0,   1, 1, 1, 1, 1, 1};

    rst  = 1'b1;
    rst2 = 1'b1;
    repeat (5) @(negedge clk);
    check_reset("reset");

    // Reduced raster, LOOKAHEAD = 0: 12 x 7 = 84 cycle frames.
    rst2 = 1'b0;
    e_pos = 0; e_fetch = 0; e_hs = 0; e_vs = 0; e_hold = 0;
    last_fs = -1; fs_gap = -1; s_fs_cnt = 0;
    for (int k = 0; k < 3 * 84; k++) begin
      @(negedge clk);
      mx  = k % 12;
      my  = (k / 12) % 7;
      xhs = !(mx >= 9 && mx < 11);
      xvs = !(my == 5);
      if (k == 0) chk("small.first_frame_start", int'(s_fs), 1);
      if (int'(s_cx) != mx || int'(s_cy) != my) e_pos++;
      if (s_fx != s_cx || s_fy != s_cy) e_fetch++;
      if (s_hs != xhs || s_vs != xvs) e_hs++;
      if (s_fs) begin
        s_fs_cnt++;
        if (last_fs >= 0 && fs_gap < 0) fs_gap = k - last_fs;
        last_fs = k;
      end
      if (cx != 10'd0 || hs != 1'b1 || fs != 1'b0) e_hold++;
    end
    chk("small.position", e_pos, 0);
    chk("small.fetch_eq_counter", e_fetch, 0);
    chk("small.sync", e_hs, 0);
    chk("small.frame_period", fs_gap, 84);
    chk("small.frame_count", s_fs_cnt, 3);
    chk("main.held_in_reset", e_hold, 0);

    // Default raster: one full frame plus part of the next, then a mid-frame reset.
    rst = 1'b0;
    ti = 0;
    e_pos = 0; e_fetch = 0; e_hs = 0; e_vs = 0; e_de = 0; e_strb = 0; e_fv = 0;
    hs_low0 = 0; de_cnt0 = 0; vs_low = 0; de_bad = 0; last_fs = -1; fs_gap = -1;
    for (int k = 0; k <= MIDK; k++) begin
      @(negedge clk);
      mx  = k % 800;
      my  = (k / 800) % 525;
      fk  = k + 2;
      mfx = fk % 800;
      mfy = (fk / 800) % 525;
      xhs = !(mx >= 656 && mx < 752);
      xvs = !(my >= 490 && my < 492);
      xde = (mx < 640) && (my < 480);
      xls = (mx == 0);
      xfs = (mx == 0) && (my == 0);
      xfv = (mfx < 640) && (mfy < 480);
      if (ti < NVEC && tbl[ti].k == k) begin
        chk($sformatf("vec%0d.cx", ti), int'(cx), tbl[ti].cx);
        chk($sformatf("vec%0d.cy", ti), int'(cy), tbl[ti].cy);
        chk($sformatf("vec%0d.fx", ti), int'(fx), tbl[ti].fx);
        chk($sformatf("vec%0d.fy", ti), int'(fy), tbl[ti].fy);
        chk($sformatf("vec%0d.hsync", ti), int'(hs), tbl[ti].hs);
        chk($sformatf("vec%0d.vsync", ti), int'(vs), tbl[ti].vs);
        chk($sformatf("vec%0d.de", ti), int'(de), tbl[ti].de);
        chk($sformatf("vec%0d.line_start", ti), int'(ls), tbl[ti].ls);
        chk($sformatf("vec%0d.frame_start", ti), int'(fs), tbl[ti].fs);
        chk($sformatf("vec%0d.fetch_valid", ti), int'(fv), tbl[ti].fv);
        ti++;
      end
      if (int'(cx) != mx || int'(cy) != my) e_pos++;
      if (int'(fx) != mfx || int'(fy) != mfy) e_fetch++;
      if (hs != xhs) e_hs++;
      if (vs != xvs) e_vs++;
      if (de != xde) e_de++;
      if (ls != xls || fs != xfs) e_strb++;
      if (fv != xfv) e_fv++;
      if (k < 800) begin
        if (!hs) hs_low0++;
        if (de) de_cnt0++;
      end
      if (k < 420000 && !vs) vs_low++;
      if (int'(cy) >= 480 && de) de_bad++;
      if (fs) begin
        if (last_fs >= 0 && fs_gap < 0) fs_gap = k - last_fs;
        last_fs = k;
      end
    end
    chk("vec_table_consumed", ti, NVEC);
    chk("run.position", e_pos, 0);
    chk("run.fetch", e_fetch, 0);
    chk("run.hsync", e_hs, 0);
    chk("run.vsync", e_vs, 0);
    chk("run.de", e_de, 0);
    chk("run.strobes", e_strb, 0);
    chk("run.fetch_valid", e_fv, 0);
    chk("line0.hsync_low_cycles", hs_low0, 96);
    chk("line0.de_cycles", de_cnt0, 640);
    chk("frame.vsync_low_cycles", vs_low, 1600);
    chk("frame.de_in_vblank", de_bad, 0);
    chk("frame.period", fs_gap, 420000);

    // Beam now at (300,200) of the second frame: pulse reset for one cycle.
    chk("mid.cx", int'(cx), 300);
    chk("mid.cy", int'(cy), 200);
    rst = 1'b1;
    @(negedge clk);
    check_reset("mid_reset");
    rst = 1'b0;
    @(negedge clk);
    chk("restart.cx", int'(cx), 0);
    chk("restart.cy", int'(cy), 0);
    chk("restart.fx", int'(fx), 2);
    chk("restart.fy", int'(fy), 0);
    chk("restart.frame_start", int'(fs), 1);
    chk("restart.line_start", int'(ls), 1);
    chk("restart.de", int'(de), 1);
    chk("restart.hsync", int'(hs), 1);
    chk("restart.vsync", int'(vs), 1);
    @(negedge clk);
    chk("restart+1.cx", int'(cx), 1);
    chk("restart+1.frame_start", int'(fs), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
